// File: rtl/level_tracker.sv
// level_tracker: stacker game progress controller (debounced place, overlap check, win/lose).
// Define PERFECT_STACK_EN to add perfect_count, a saturating run of full-overlap placements.
module level_tracker #(
    parameter int ROW_W           = 8,
    parameter int MAX_LEVEL       = 15,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             place_btn,
    input  logic             restart,
    input  logic [ROW_W-1:0] moving_row,
    output logic [3:0]       current_level,
    output logic [ROW_W-1:0] stack_row,
    output logic [3:0]       row_width,
    output logic             level_up,
    output logic             game_over,
    output logic             game_won
`ifdef PERFECT_STACK_EN
    ,
    output logic [3:0]       perfect_count
`endif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {PLAY, CHECK, WIN, LOSE} state_t;

    state_t           state, nxt_state;
    logic             sync1, sync2, db_level, db_prev, place_pulse;
    logic [CW-1:0]    db_cnt;
    logic [ROW_W-1:0] cap_row, nxt_cap, nxt_stack, ov;
    logic [3:0]       nxt_level;
`ifdef PERFECT_STACK_EN
    logic [3:0]       nxt_perf;
`endif

    // Debouncer is deliberately untouched by restart so a held button cannot retrigger.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1   <= place_btn;
            sync2   <= sync1;
            db_prev <= db_level;
            if (sync2 == db_level)
                db_cnt <= '0;
            else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else
                db_cnt <= db_cnt + CW'(1);
        end
    end

    assign place_pulse = db_level & ~db_prev;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= PLAY;
            cap_row       <= '0;
            stack_row     <= '1;
            current_level <= '0;
`ifdef PERFECT_STACK_EN
            perfect_count <= '0;
`endif
        end else begin
            state         <= nxt_state;
            cap_row       <= nxt_cap;
            stack_row     <= nxt_stack;
            current_level <= nxt_level;
`ifdef PERFECT_STACK_EN
            perfect_count <= nxt_perf;
`endif
        end
    end

    always_comb begin
        ov        = cap_row & stack_row;
        nxt_state = state;
        nxt_cap   = cap_row;
        nxt_stack = stack_row;
        nxt_level = current_level;
        level_up  = 1'b0;
`ifdef PERFECT_STACK_EN
        nxt_perf  = perfect_count;
`endif
        if (restart) begin
            nxt_state = PLAY;
            nxt_cap   = '0;
            nxt_stack = '1;
            nxt_level = '0;
`ifdef PERFECT_STACK_EN
            nxt_perf  = '0;
`endif
        end else if (state == PLAY && place_pulse) begin
            nxt_cap   = moving_row;
            nxt_state = CHECK;
        end else if (state == CHECK) begin
            if (ov == '0)
                nxt_state = LOSE;
            else begin
                nxt_stack = ov;
                nxt_level = current_level + 4'd1;
                level_up  = reset_n;
                nxt_state = (current_level + 4'd1 == 4'(MAX_LEVEL)) ? WIN : PLAY;
`ifdef PERFECT_STACK_EN
                nxt_perf  = (ov == stack_row) ? ((perfect_count == 4'd15) ? 4'd15 : perfect_count + 4'd1) : 4'd0;
`endif
            end
        end
    end

    always_comb begin
        row_width = '0;
        for (int i = 0; i < ROW_W; i++)
            row_width = row_width + 4'(stack_row[i]);
    end

    assign game_over = (state == LOSE);
    assign game_won  = (state == WIN);
endmodule
